nios_cpu_oci_dct_sequencer: RTL

- Sequences the OCI debug-trace compression (DCT) datapath for the Nios II CPU.
- Packs 2-bit trace atoms into the 30-bit dct_buffer and tracks dct_count.
- Hands full or partial words to the on-chip trace RAM through a valid/ready write port.
- Drives the test_ending / test_has_ended flush handshake used by the OCI test bench.

---
 rtl/nios_cpu_oci_dct_sequencer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/nios_cpu_oci_dct_sequencer.sv
// Nios II OCI debug-trace compression sequencer.
// Packs 2-bit trace atoms into a 30-bit word, hands full and partial words to
// the on-chip trace RAM over a valid/ready port, and runs the end-of-test flush.
module nios_cpu_oci_dct_sequencer #(
    parameter int TRACE_ADDR_W   = 7,
    parameter int ATOMS_PER_WORD = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    trace_enable,
    input  logic                    flush_req,
    input  logic                    atom_valid,
    input  logic [1:0]              atom,
    output logic                    atom_ready,
    output logic                    tw_valid,
    input  logic                    tw_ready,
    output logic [33:0]             tw_data,
    output logic [TRACE_ADDR_W-1:0] tw_addr,
    output logic                    wrapped,
    output logic [29:0]             dct_buffer,
    output logic [3:0]              dct_count,
    output logic                    test_ending,
    output logic                    test_has_ended
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Count stamped on a full word, and the count at which the next accept fills it.
    localparam logic [3:0] CNT_FULL = 4'(ATOMS_PER_WORD);
    localparam logic [3:0] CNT_LAST = 4'(ATOMS_PER_WORD - 1);

    state_t                  state_q, state_d;
    logic [29:0]             buf_q, buf_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    tw_valid_q, tw_valid_d;
    logic [33:0]             tw_data_q, tw_data_d;
    logic [TRACE_ADDR_W-1:0] tw_addr_q, tw_addr_d;
    logic                    wrapped_q, wrapped_d;
    logic                    test_ending_q, test_ending_d;
    logic                    test_has_ended_q, test_has_ended_d;

    logic                    atom_ready_w;
    logic                    accept;
    logic                    tw_fire;
    logic                    load;
    logic [33:0]             load_data;
    logic [29:0]             shifted;

    // Next-state logic: packing, write handshake, address/wrap tracking and flush sequencing.
    always_comb begin
        state_d          = state_q;
        buf_d            = buf_q;
        cnt_d            = cnt_q;
        tw_valid_d       = tw_valid_q;
        tw_data_d        = tw_data_q;
        tw_addr_d        = tw_addr_q;
        wrapped_d        = wrapped_q;
        load             = 1'b0;
        load_data        = '0;

        // Stall the atom that would complete a word while the previous word is
        // still pending, regardless of tw_ready, so the ready path has no
        // combinational dependence on the RAM side.
        atom_ready_w     = (state_q == ST_RUN) && !(tw_valid_q && (cnt_q == CNT_LAST));
        accept           = atom_valid && atom_ready_w;
        tw_fire          = tw_valid_q && tw_ready;
        shifted          = {buf_q[27:0], atom};

        if (tw_fire) begin
            tw_valid_d = 1'b0;
            tw_addr_d  = tw_addr_q + 1'b1;
            if (tw_addr_q == '1) begin
                wrapped_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                buf_d = '0;
                cnt_d = '0;
                if (trace_enable) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // The atom taken in the cycle that ends tracing is still packed.
                if (accept) begin
                    if (cnt_q == CNT_LAST) begin
                        load      = 1'b1;
                        load_data = {CNT_FULL, shifted};
                        buf_d     = '0;
                        cnt_d     = '0;
                    end else begin
                        buf_d = shifted;
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                if (flush_req || !trace_enable) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (!tw_valid_q) begin
                    if (cnt_q != 4'd0) begin
                        // Buffer was shifted up from zero, so unused upper bits are already 0.
                        load      = 1'b1;
                        load_data = {cnt_q, buf_q};
                        buf_d     = '0;
                        cnt_d     = '0;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else if (tw_fire && (cnt_q == 4'd0)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                buf_d = '0;
                cnt_d = '0;
                if (!trace_enable) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A freshly loaded word wins over the acceptance of the previous one.
        if (load) begin
            tw_valid_d = 1'b1;
            tw_data_d  = load_data;
        end

        test_ending_d    = (state_d == ST_FLUSH);
        test_has_ended_d = (state_d == ST_DONE);
    end

    // State and output registers; reset discards any pending word outright.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            buf_q            <= '0;
            cnt_q            <= '0;
            tw_valid_q       <= 1'b0;
            tw_data_q        <= '0;
            tw_addr_q        <= '0;
            wrapped_q        <= 1'b0;
            test_ending_q    <= 1'b0;
            test_has_ended_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            buf_q            <= buf_d;
            cnt_q            <= cnt_d;
            tw_valid_q       <= tw_valid_d;
            tw_data_q        <= tw_data_d;
            tw_addr_q        <= tw_addr_d;
            wrapped_q        <= wrapped_d;
            test_ending_q    <= test_ending_d;
            test_has_ended_q <= test_has_ended_d;
        end
    end

    assign atom_ready     = atom_ready_w;
    assign tw_valid       = tw_valid_q;
    assign tw_data        = tw_data_q;
    assign tw_addr        = tw_addr_q;
    assign wrapped        = wrapped_q;
    assign dct_buffer     = buf_q;
    assign dct_count      = cnt_q;
    assign test_ending    = test_ending_q;
    assign test_has_ended = test_has_ended_q;

endmodule
